// File: rtl/xgriscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   state_t  : arbiter FSM encoding (ST_IDLE, ST_WAIT)
//   SEL_IF / SEL_DM : which requester owns the access in flight
//   BE_WORD  : byte-enable pattern used for instruction fetches
package xgriscv_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/xgriscv_rr_pick.sv
// Winner select between fetch and data requesters, with a starvation guard.
//   clk, reset : clock and synchronous active-high reset
//   if_req     : fetch request pending
//   dm_req     : data request pending
//   grant      : an access is issued this cycle to the winner reported on sel
//   sel        : combinational winner (SEL_IF / SEL_DM)
// Data normally wins a tie. streak counts data grants issued while fetch was
// left waiting; once it reaches STARVE_MAX the next tie goes to fetch.
module xgriscv_rr_pick
    import xgriscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant,
    output logic sel
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);
    localparam bit GUARD_ON = (STARVE_MAX > 0);

    logic [SW-1:0] streak_reg;
    logic [SW-1:0] streak_next;
    logic          force_if;

    always_comb begin
        force_if    = GUARD_ON && (streak_reg == STREAK_LIM);
        sel         = SEL_IF;
        streak_next = streak_reg;
        if (dm_req && !(if_req && force_if)) begin
            sel = SEL_DM;
        end
        if (grant) begin
            if (sel == SEL_IF) begin
                streak_next = '0;
            end else if (if_req && (streak_reg != STREAK_LIM)) begin
                // Only data grants that made fetch wait count towards starvation.
                streak_next = streak_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data access. One access in flight at a time; each requester gets a single
// cycle ack carrying read data exactly MEM_LAT cycles after its mem_en cycle.
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (held until if_ack)
//   if_ack/if_rdata       : fetch completion pulse and instruction
//   dm_req/we/addr/wdata/be : data request (held until dm_ack)
//   dm_ack/dm_rdata       : data completion pulse and load data (0 for stores)
//   mem_en/we/addr/wdata/be : memory access, mem_en one cycle per access
//   mem_rdata             : memory read data, valid MEM_LAT cycles after mem_en
//   busy                  : high while an access is in flight
module xgriscv_mem_arbiter
    import xgriscv_mem_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       sel_reg, sel_next;
    logic       we_reg, we_next;
    logic       pick_sel;
    logic       grant;

    // Reset also masks the combinational outputs so nothing leaves the block
    // (no strobe, no ack) in any cycle where reset is asserted.
    assign grant = !reset && (state_reg == ST_IDLE) && (if_req || dm_req);

    xgriscv_rr_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .dm_req (dm_req),
        .grant  (grant),
        .sel    (pick_sel)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        we_next    = we_reg;
        if_ack     = 1'b0;
        if_rdata   = '0;
        dm_ack     = 1'b0;
        dm_rdata   = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        busy       = 1'b0;
        if (!reset) begin
            case (state_reg)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        mem_en = 1'b1;
                        if (pick_sel == SEL_DM) begin
                            mem_we    = dm_we;
                            mem_addr  = dm_addr;
                            mem_wdata = dm_wdata;
                            mem_be    = dm_be;
                        end else begin
                            mem_addr = if_addr;
                            mem_be   = BE_WORD;
                        end
                        sel_next   = pick_sel;
                        we_next    = (pick_sel == SEL_DM) && dm_we;
                        cnt_next   = 4'(MEM_LAT);
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    busy     = 1'b1;
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        if (sel_reg == SEL_DM) begin
                            dm_ack   = 1'b1;
                            dm_rdata = we_reg ? 32'h0 : mem_rdata;
                        end else begin
                            if_ack   = 1'b1;
                            if_rdata = mem_rdata;
                        end
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sel_reg   <= SEL_IF;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
        end
    end

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Directed bench for xgriscv_mem_arbiter with MEM_LAT=2. A second instance with
// STARVE_MAX=0 shares the stimulus to observe pure data priority.
module tb_xgriscv_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;

    logic        if_ack, dm_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        d0_if_ack, d0_dm_ack, d0_mem_en, d0_mem_we, d0_busy;
    logic [31:0] d0_if_rdata, d0_dm_rdata, d0_mem_addr, d0_mem_wdata;
    logic [3:0]  d0_mem_be;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    xgriscv_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    xgriscv_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(0)) dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(d0_if_ack), .if_rdata(d0_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(d0_dm_ack), .dm_rdata(d0_dm_rdata),
        .mem_en(d0_mem_en), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr),
        .mem_wdata(d0_mem_wdata), .mem_be(d0_mem_be), .mem_rdata(32'h0), .busy(d0_busy)
    );

    // Fixed-latency RAM model: read captured at the mem_en edge, shifted LAT-1 more stages.
    logic [31:0] ram [0:255];
    logic [31:0] pipe [0:LAT-1];

    always @(posedge clk) begin
        if (mem_en) begin
            pipe[0] <= ram[mem_addr[9:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end else begin
            pipe[0] <= 32'h0;
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
        ram[4]  = 32'h00500113;
        ram[64] = 32'hCAFE0001;

        // Reset state
        step(); step(); half();
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        step(); reset = 1'b0; half();
        chk("idle_mem_en", {31'h0, mem_en}, 32'h0);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("idle_acks", {30'h0, if_ack, dm_ack}, 32'h0);

        // Single fetch
        step(); if_req = 1'b1; if_addr = 32'h10; half();
        chk("f_mem_en", {31'h0, mem_en}, 32'h1);
        chk("f_mem_be", {28'h0, mem_be}, 32'hF);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_we", {31'h0, mem_we}, 32'h0);
        chk("f_busy_t", {31'h0, busy}, 32'h0);
        step(); half();
        chk("f_busy_t1", {31'h0, busy}, 32'h1);
        chk("f_ack_t1", {31'h0, if_ack}, 32'h0);
        step(); half();
        chk("f_ack_t2", {31'h0, if_ack}, 32'h1);
        chk("f_rdata", if_rdata, 32'h00500113);
        chk("f_busy_t2", {31'h0, busy}, 32'h1);
        $display("txn fetch addr=00000010 rdata=%08h", if_rdata);
        step(); if_req = 1'b0; half();
        chk("f_done_busy", {31'h0, busy}, 32'h0);

        // Simultaneous requests: data first, then fetch
        step(); if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; half();
        chk("b_first_addr", mem_addr, 32'h100);
        chk("b_first_we", {31'h0, mem_we}, 32'h0);
        step(); half(); step(); half();
        chk("b_dm_ack", {31'h0, dm_ack}, 32'h1);
        chk("b_dm_rdata", dm_rdata, 32'hCAFE0001);
        chk("b_if_noack", {31'h0, if_ack}, 32'h0);
        $display("txn load addr=00000100 rdata=%08h", dm_rdata);
        step(); dm_req = 1'b0; half();
        chk("b_fetch_en", {31'h0, mem_en}, 32'h1);
        chk("b_fetch_addr", mem_addr, 32'h10);
        chk("b_fetch_be", {28'h0, mem_be}, 32'hF);
        step(); half(); step(); half();
        chk("b_if_ack", {31'h0, if_ack}, 32'h1);
        chk("b_if_rdata", if_rdata, 32'h00500113);
        $display("txn fetch addr=00000010 rdata=%08h", if_rdata);
        step(); if_req = 1'b0; half();

        // Store with partial byte enables, then load back
        step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011; half();
        chk("s_mem_we", {31'h0, mem_we}, 32'h1);
        chk("s_mem_be", {28'h0, mem_be}, 32'h3);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_mem_addr", mem_addr, 32'h20);
        step(); half(); step(); half();
        chk("s_dm_ack", {31'h0, dm_ack}, 32'h1);
        chk("s_dm_rdata", dm_rdata, 32'h0);
        $display("txn store addr=00000020 wdata=deadbeef be=3");
        step(); dm_we = 1'b0; dm_wdata = 32'h0; dm_be = 4'hF; half();
        chk("l_mem_en", {31'h0, mem_en}, 32'h1);
        chk("l_mem_we", {31'h0, mem_we}, 32'h0);
        step(); half(); step(); half();
        chk("l_dm_ack", {31'h0, dm_ack}, 32'h1);
        chk("l_dm_rdata", dm_rdata, 32'h0000BEEF);
        $display("txn load addr=00000020 rdata=%08h", dm_rdata);
        step(); dm_req = 1'b0; half();

        // Starvation guard: both requests held continuously
        step(); if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h100; dm_we = 1'b0; half();
        for (int g = 0; g < 10; g++) begin
            int w;
            w = 0;
            while (!mem_en && w < 10) begin
                step(); half();
                w++;
            end
            chk("g_seen", {31'h0, mem_en}, 32'h1);
            chk($sformatf("g%0d_addr", g), mem_addr, exp_d[g] ? 32'h100 : 32'h10);
            chk($sformatf("g%0d_d0_en", g), {31'h0, d0_mem_en}, 32'h1);
            chk($sformatf("g%0d_d0_addr", g), d0_mem_addr, 32'h100);
            $display("txn grant %0d %s", g, (mem_addr == 32'h100) ? "D" : "I");
            step();
        end
        half(); step(); half();
        chk("g_last_if_ack", {31'h0, if_ack}, 32'h1);
        step(); if_req = 1'b0; dm_req = 1'b0; half();

        // Reset in the middle of WAIT
        step(); dm_req = 1'b1; dm_addr = 32'h100; half();
        chk("r_issue", {31'h0, mem_en}, 32'h1);
        step(); reset = 1'b1; half();
        chk("r_masked_busy", {31'h0, busy}, 32'h0);
        step(); half();
        chk("r_no_ack", {31'h0, dm_ack}, 32'h0);
        chk("r_mem_en0", {31'h0, mem_en}, 32'h0);
        chk("r_busy0", {31'h0, busy}, 32'h0);
        step(); reset = 1'b0; half();
        chk("r_reissue_en", {31'h0, mem_en}, 32'h1);
        chk("r_reissue_addr", mem_addr, 32'h100);
        chk("r_reissue_noack", {31'h0, dm_ack}, 32'h0);
        step(); half();
        chk("r_wait_noack", {31'h0, dm_ack}, 32'h0);
        chk("r_wait_busy", {31'h0, busy}, 32'h1);
        step(); half();
        chk("r_dm_ack", {31'h0, dm_ack}, 32'h1);
        chk("r_dm_rdata", dm_rdata, 32'hCAFE0001);
        $display("txn load after reset addr=00000100 rdata=%08h", dm_rdata);
        step(); dm_req = 1'b0; half();
        chk("r_done_busy", {31'h0, busy}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
